angle_search: RTL and testbench

ANGLE_SEARCH -- requirements
Module: angle_search

---
 rtl/angle_search_pkg.sv | 15 +
 rtl/angle_search.sv | 119 +++++++++++
 tb/tb_angle_search.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/angle_search_pkg.sv
// Shared types and angle constants for the beam angle search.
package angle_search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic signed [7:0] ANG_MIN = -8'sd90;
  localparam logic signed [7:0] ANG_MAX = 8'sd90;
  localparam int                N_ANG   = 37;

endpackage

// File: rtl/angle_search.sv
// angle_search: sweeps the steering angle from -90 to +90 degrees. One power
// measurement is requested per angle. The strongest angle is reported, and the
// earliest angle wins a tie.
// Optional build macro ANGSEARCH_THRESH_EN: a sweep whose peak power is below
// PWR_THRESH leaves angle unchanged. wbdone still pulses for that sweep.
module angle_search
  import angle_search_pkg::*;
#(
  parameter int                PWR_W      = 32,
  parameter int                ANG_STEP   = 5,
  parameter logic [PWR_W-1:0]  PWR_THRESH = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    steer_valid,
  output logic signed [7:0]       steer_ang,
  input  logic                    pwr_valid,
  input  logic [PWR_W-1:0]        pwr_data,
  output logic                    busy,
  output logic signed [7:0]       angle,
  output logic                    wbdone
);

  localparam logic signed [7:0] STEP = 8'(ANG_STEP);

  state_t                  state_reg,     state_next;
  logic signed [7:0]       steer_ang_reg, steer_ang_next;
  logic [PWR_W-1:0]        best_pwr_reg,  best_pwr_next;
  logic signed [7:0]       best_ang_reg,  best_ang_next;
  logic signed [7:0]       angle_reg,     angle_next;

  // Running best including the response being accepted this cycle.
  logic                    new_peak;
  logic [PWR_W-1:0]        final_pwr;
  logic signed [7:0]       final_ang;
  logic                    accept;

  assign new_peak  = pwr_data > best_pwr_reg;
  assign final_pwr = new_peak ? pwr_data : best_pwr_reg;
  assign final_ang = new_peak ? steer_ang_reg : best_ang_reg;

`ifdef ANGSEARCH_THRESH_EN
  assign accept = final_pwr >= PWR_THRESH;
`else
  assign accept = 1'b1;
  // The threshold is referenced only at elaboration time, so no logic is built from it.
  if (PWR_THRESH != '0) begin : g_thresh_ignored
  end
`endif

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      steer_ang_reg <= '0;
      best_pwr_reg  <= '0;
      best_ang_reg  <= '0;
      angle_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      steer_ang_reg <= steer_ang_next;
      best_pwr_reg  <= best_pwr_next;
      best_ang_reg  <= best_ang_next;
      angle_reg     <= angle_next;
    end
  end

  // Next-state and datapath updates for the sweep.
  // angle is loaded on entry to DONE, so it is already valid while wbdone is high.
  always_comb begin
    state_next     = state_reg;
    steer_ang_next = steer_ang_reg;
    best_pwr_next  = best_pwr_reg;
    best_ang_next  = best_ang_reg;
    angle_next     = angle_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = REQ;
          steer_ang_next = ANG_MIN;
          best_pwr_next  = '0;
          best_ang_next  = ANG_MIN;
        end
      end
      REQ: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (pwr_valid) begin
          best_pwr_next = final_pwr;
          best_ang_next = final_ang;
          if (steer_ang_reg == ANG_MAX) begin
            state_next = DONE;
            if (accept) begin
              angle_next = final_ang;
            end
          end else begin
            steer_ang_next = steer_ang_reg + STEP;
            state_next     = REQ;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign steer_valid = (state_reg == REQ);
  assign wbdone      = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign steer_ang   = steer_ang_reg;
  assign angle       = angle_reg;

endmodule

// File: tb/tb_angle_search.sv
// Self-checking bench for angle_search.
// Expected angles are queued when a sweep starts and checked when wbdone pulses.
`timescale 1ns/1ps
module tb_angle_search;

`ifdef ANGSEARCH_THRESH_EN
  localparam logic [31:0] THRESH = 32'd1000;
`else
  localparam logic [31:0] THRESH = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              steer_valid;
  logic signed [7:0] steer_ang;
  logic              pwr_valid;
  logic [31:0]       pwr_data;
  logic              busy;
  logic signed [7:0] angle;
  logic              wbdone;

  always #5 clk = ~clk;

  angle_search #(.PWR_W(32), .ANG_STEP(5), .PWR_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .steer_valid(steer_valid), .steer_ang(steer_ang),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data),
    .busy(busy), .angle(angle), .wbdone(wbdone)
  );

  int                tests = 0;
  int                fails = 0;
  logic [31:0]       pwr_tab [37];
  int                lat = 0;
  bit                stray = 0;
  logic signed [7:0] exp_q [$];
  int                steer_cnt = 0;
  int                wbdone_cnt = 0;
  logic signed [7:0] model_angle = 8'sd0;

  typedef struct {
    string             name;
    logic [31:0]       base;
    int                i1;
    logic [31:0]       v1;
    int                i2;
    logic [31:0]       v2;
    int                l;
    bit                s;
    bit                extra;
    logic signed [7:0] exp_ang;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_tab(input logic [31:0] base, input int i1, input logic [31:0] v1,
                          input int i2, input logic [31:0] v2);
    for (int i = 0; i < 37; i++) pwr_tab[i] = base;
    pwr_tab[i1] = v1;
    pwr_tab[i2] = v2;
  endtask

  // Beamformer model: answers each request after lat WAIT cycles.
  // When stray is set, it also drives a stray huge power during REQ.
  initial begin
    bit pend = 0;
    int cnt = 0;
    int idx = 0;
    pwr_valid = 1'b0;
    pwr_data  = '0;
    forever begin
      @(posedge clk); #1;
      pwr_valid = 1'b0;
      pwr_data  = '0;
      if (reset) pend = 0;
      if (pend) begin
        if (cnt == 0) begin
          pwr_valid = 1'b1;
          pwr_data  = pwr_tab[idx];
          pend      = 0;
        end else begin
          cnt--;
        end
      end
      if (steer_valid) begin
        pend = 1;
        cnt  = lat;
        idx  = (int'(steer_ang) + 90) / 5;
        if (idx < 0 || idx > 36) idx = 0;
        if (stray) begin
          pwr_valid = 1'b1;
          pwr_data  = 32'hFFFF_FFFF;
        end
      end
    end
  end

  // Monitor: checks the steering sequence and scores each wbdone.
  initial begin
    logic signed [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (steer_valid) begin
        check("steer_ang", steer_ang, -90 + 5 * steer_cnt);
        steer_cnt++;
      end
      if (wbdone) begin
        wbdone_cnt++;
        check("wbdone_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("angle", angle, e);
        end
      end
    end
  end

  task automatic run_sweep(input string name, input int l, input bit s, input bit extra,
                           input logic signed [7:0] exp_ang);
    int          cyc = 0;
    int          wb0;
    logic [31:0] pk = '0;
    for (int i = 0; i < 37; i++) if (pwr_tab[i] > pk) pk = pwr_tab[i];
    if (pk >= THRESH) model_angle = exp_ang;
    exp_q.push_back(model_angle);
    lat = l; stray = s; steer_cnt = 0; wb0 = wbdone_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({name, " busy_after_start"}, busy, 1);
    while (!wbdone && cyc < 3000) begin
      start = (extra && (cyc == 30 || cyc == 31));
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({name, " wbdone_seen"}, wbdone, 1);
    if (!wbdone) exp_q.delete();
    if (l == 0) check({name, " start_to_wbdone"}, cyc, 75);
    check({name, " busy_at_wbdone"}, busy, 1);
    @(posedge clk); #1;
    check({name, " wbdone_one_cycle"}, wbdone, 0);
    check({name, " busy_cleared"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, " steer_pulses"}, steer_cnt, 37);
    check({name, " wbdone_count"}, wbdone_cnt - wb0, 1);
    $display("[TB] sweep %s: angle=%0d expected=%0d", name, angle, model_angle);
    stray = 0;
  endtask

  initial begin
    int n;
    int wb0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 37; i++) pwr_tab[i] = '0;

    vecs[0] = '{"peak_p35",      32'd100,         25, 32'd900,       25, 32'd900,       0, 0, 0,  8'sd35};
    vecs[1] = '{"tie_m40_p10",   32'd0,           10, 32'd500,       20, 32'd500,       0, 0, 0, -8'sd40};
    vecs[2] = '{"all_zero",      32'd0,            0, 32'd0,          0, 32'd0,         0, 0, 0, -8'sd90};
    vecs[3] = '{"peak_p90",      32'd7,           36, 32'd50,        36, 32'd50,        0, 0, 0,  8'sd90};
    vecs[4] = '{"peak_m90",      32'd100,          0, 32'd900,        0, 32'd900,       0, 0, 0, -8'sd90};
    vecs[5] = '{"flat_tie",      32'd1000,         0, 32'd1000,       0, 32'd1000,      0, 0, 0, -8'sd90};
    vecs[6] = '{"max_unsigned",  32'h8000_0000,   19, 32'hFFFF_FFFF, 19, 32'hFFFF_FFFF, 0, 0, 0,  8'sd5};
    vecs[7] = '{"lat3_stray",    32'd100,         25, 32'd900,       25, 32'd900,       3, 1, 1,  8'sd35};
    vecs[8] = '{"lat1_close",    32'd100,          3, 32'd400,       30, 32'd401,       1, 0, 0,  8'sd60};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset angle", angle, 0);
    check("reset wbdone", wbdone, 0);
    check("reset busy", busy, 0);
    check("reset steer_valid", steer_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    check("idle no steer", steer_cnt, 0);
    check("idle busy", busy, 0);

    for (int v = 0; v < 9; v++) begin
      load_tab(vecs[v].base, vecs[v].i1, vecs[v].v1, vecs[v].i2, vecs[v].v2);
      run_sweep(vecs[v].name, vecs[v].l, vecs[v].s, vecs[v].extra, vecs[v].exp_ang);
    end

    // Abort a sweep after 20 requests. No wbdone may follow, and angle returns to 0.
    load_tab(32'd100, 25, 32'd900, 25, 32'd900);
    lat = 0; steer_cnt = 0; wb0 = wbdone_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (steer_cnt < 20 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort reached 20 requests", steer_cnt >= 20, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_angle = 8'sd0;
    check("abort angle", angle, 0);
    check("abort busy", busy, 0);
    repeat (80) @(posedge clk);
    #1;
    check("abort no wbdone", wbdone_cnt - wb0, 0);
    check("abort idle busy", busy, 0);

    load_tab(32'd100, 25, 32'd900, 25, 32'd900);
    run_sweep("after_abort", 0, 0, 0, 8'sd35);

`ifdef ANGSEARCH_THRESH_EN
    load_tab(32'd10, 0, 32'd2000, 0, 32'd2000);
    run_sweep("thresh_pass_m90", 0, 0, 0, -8'sd90);
    load_tab(32'd10, 30, 32'd50, 30, 32'd50);
    run_sweep("thresh_hold", 0, 0, 0, 8'sd60);
    check("thresh held angle", angle, -90);
`endif

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
